control_multiciclo: RTL and testbench
=====================================

// Module: control_multiciclo
// PURPOSE
//  Multicycle main control FSM for the MIPS-subset datapath; successor to the single-cycle decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per opcode, with a ready handshake to a shared instr/data memory.
//  Adds a wait-timeout counter and an illegal-opcode flag.
//  Sits between the IR opcode field and the datapath muxes/enables.
// PARAMETERS
//  OPCODE_W  6   opcode field width (fixed encodings below use 6 LSBs)
//  ALUOP_W   2   width of ALUOp to ALU control (00 add, 01 sub, 10 funct; upper bits 0)
//  TIMEOUT   16  max cycles waiting on mem_listo before abort; 0 = wait forever
//  EN_INMED  1   1 = ADDI (001000) supported; 0 = ADDI treated as illegal
// PORTS
//  clk         in  1         rising-edge clock
//  reset       in  1         asynchronous, active-high
//  opcode      in  OPCODE_W  IR[31:26], valid from DECODE on
//  mem_listo   in  1         memory ready/ack for current LeerMem/EscrMem
//  EscrPC      out 1         unconditional PC write
//  EscrPCCond  out 1         PC write if ALU zero (BEQ)
//  IoD         out 1         0 = PC addresses memory, 1 = ALUOut
//  LeerMem     out 1         memory read request
//  EscrMem     out 1         memory write request
//  EscrIR      out 1         IR load
//  MemaReg     out 1         1 = write-back data from MDR, 0 = ALUOut
//  RegDest     out 1         1 = rd, 0 = rt
//  EscrReg     out 1         register file write
//  FuenteALUA  out 1         0 = PC, 1 = rs
//  FuenteALUB  out 2         00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUOp       out ALUOP_W   ALU control class
//  FuentePC    out 2         00 ALU, 01 ALUOut, 10 jump target
//  estado      out 4         current state code (debug)
//  excepcion   out 1         1-cycle pulse: illegal opcode or memory timeout
// BEHAVIOUR
//  - Outputs decoded from state (Moore), except mem-gated enables noted. Unlisted outputs = 0.
//  - While reset high: state=FETCH(0); all outputs 0 (gated by reset), wait counter=0.
//  - FETCH(0): LeerMem, FuenteALUB=01, ALUOp=00; EscrIR, EscrPC only in cycle mem_listo=1
//    -> DECODE; else stay.
//  - DECODE(1): FuenteALUB=11, ALUOp=00. By opcode: 100011/101011 -> MEMADR(2); 000000 -> EXEC(6);
//    000100 -> BRANCH(8); 000010 -> JUMP(9); 001000 & EN_INMED -> ADDIEX(10);
//    else excepcion=1 -> FETCH.
//  - MEMADR(2): FuenteALUA=1, FuenteALUB=10. -> MEMRD(3) if LW, MEMWR(5) if SW.
//  - MEMRD(3): LeerMem, IoD; stay until mem_listo -> MEMWB(4).
//    MEMWB(4): EscrReg, MemaReg, RegDest=0 -> FETCH.
//  - MEMWR(5): EscrMem, IoD; stay until mem_listo -> FETCH.
//  - EXEC(6): FuenteALUA=1, FuenteALUB=00, ALUOp=10 -> RWB(7): EscrReg, RegDest=1 -> FETCH.
//  - BRANCH(8): FuenteALUA=1, FuenteALUB=00, ALUOp=01, EscrPCCond, FuentePC=01 -> FETCH.
//  - JUMP(9): EscrPC, FuentePC=10 -> FETCH.
//  - ADDIEX(10): FuenteALUA=1, FuenteALUB=10, ALUOp=00 -> ADDIWB(11): EscrReg, RegDest=0 -> FETCH.
//  - CPI: R/ADDI 4, LW 5, SW 4, BEQ/J 3 (each mem state +N wait cycles).
//  - Wait counter: cleared on entering FETCH/MEMRD/MEMWR and on any state change.
//    Increments each cycle in those states with mem_listo=0. If TIMEOUT!=0 and count reaches TIMEOUT:
//    excepcion=1, no write enables asserted that cycle, -> FETCH (PC not advanced).
//  - mem_listo asserted outside FETCH/MEMRD/MEMWR is ignored.
//  - Unused state codes 12-15 -> FETCH next cycle, excepcion=1.
//  - Async reset mid-instruction: abandon immediately; no partial register/memory write after reset.
// TESTING
//  - Reset with mem_listo=1 held -> all outputs 0, estado=0; after release FETCH asserts EscrPC+EscrIR.
//  - R-type 000000, mem_listo=1 -> estado 0,1,6,7,0; EscrReg=1 RegDest=1 only in state 7; ALUOp=10 in 6.
//  - LW 100011, mem_listo low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; EscrReg+MemaReg in 4.
//  - SW with mem_listo never high, TIMEOUT=16 -> 16 cycles in MEMWR, excepcion pulse, back to 0, EscrMem then 0.
//  - Opcode 111111 -> DECODE pulses excepcion, next state 0; with EN_INMED=0, 001000 behaves same.
//  - BEQ 000100 -> states 0,1,8,0 with EscrPCCond=1 FuentePC=01 in 8; J 000010 -> EscrPC, FuentePC=10 in 9.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multicycle MIPS-subset main control: Moore FSM with mem_listo-gated fetch enables,
// memory-wait timeout and illegal-opcode exception pulse. Outputs are combinational from state_q.
module control_multiciclo #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 16,
  parameter int EN_INMED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_listo,
  output logic                EscrPC,
  output logic                EscrPCCond,
  output logic                IoD,
  output logic                LeerMem,
  output logic                EscrMem,
  output logic                EscrIR,
  output logic                MemaReg,
  output logic                RegDest,
  output logic                EscrReg,
  output logic                FuenteALUA,
  output logic [1:0]          FuenteALUB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          FuentePC,
  output logic [3:0]          estado,
  output logic                excepcion
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op;
  logic             wait_st;
  logic             timeout;

  assign op = opcode[5:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    EscrPC     = 1'b0;
    EscrPCCond = 1'b0;
    IoD        = 1'b0;
    LeerMem    = 1'b0;
    EscrMem    = 1'b0;
    EscrIR     = 1'b0;
    MemaReg    = 1'b0;
    RegDest    = 1'b0;
    EscrReg    = 1'b0;
    FuenteALUA = 1'b0;
    FuenteALUB = 2'b00;
    ALUOp      = '0;
    FuentePC   = 2'b00;
    excepcion  = 1'b0;
    estado     = state_q;

    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout = (TIMEOUT != 0) && wait_st && !mem_listo && (cnt_q == CNT_W'(TIMEOUT - 1));

    case (state_q)
      S_FETCH: begin
        LeerMem    = 1'b1;
        FuenteALUB = 2'b01;
        if (mem_listo) begin
          EscrIR  = 1'b1;
          EscrPC  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        FuenteALUB = 2'b11;
        if (op == OP_LW || op == OP_SW)             state_d = S_MEMADR;
        else if (op == OP_RTYPE)                    state_d = S_EXEC;
        else if (op == OP_BEQ)                      state_d = S_BRANCH;
        else if (op == OP_J)                        state_d = S_JUMP;
        else if (op == OP_ADDI && EN_INMED != 0)    state_d = S_ADDIEX;
        else begin
          excepcion = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: begin
        FuenteALUA = 1'b1;
        FuenteALUB = 2'b10;
        state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        LeerMem = 1'b1;
        IoD     = 1'b1;
        if (mem_listo) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        EscrReg = 1'b1;
        MemaReg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        EscrMem = 1'b1;
        IoD     = 1'b1;
        if (mem_listo) state_d = S_FETCH;
      end
      S_EXEC: begin
        FuenteALUA = 1'b1;
        ALUOp      = ALUOP_W'(2'b10);
        state_d    = S_RWB;
      end
      S_RWB: begin
        EscrReg = 1'b1;
        RegDest = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        FuenteALUA = 1'b1;
        ALUOp      = ALUOP_W'(2'b01);
        EscrPCCond = 1'b1;
        FuentePC   = 2'b01;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        EscrPC   = 1'b1;
        FuentePC = 2'b10;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        FuenteALUA = 1'b1;
        FuenteALUB = 2'b10;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        EscrReg = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        excepcion = 1'b1;
        state_d   = S_FETCH;
      end
    endcase

    // Abort on memory timeout: suppress every write so the PC does not advance.
    if (timeout) begin
      excepcion  = 1'b1;
      state_d    = S_FETCH;
      EscrPC     = 1'b0;
      EscrPCCond = 1'b0;
      EscrIR     = 1'b0;
      EscrMem    = 1'b0;
      EscrReg    = 1'b0;
    end

    if (state_d != state_q || timeout) cnt_d = '0;
    else if (wait_st && !mem_listo && TIMEOUT != 0) cnt_d = cnt_q + 1'b1;

    // Reset gates outputs combinationally so an abandoned instruction writes nothing.
    if (reset) begin
      EscrPC     = 1'b0;
      EscrPCCond = 1'b0;
      IoD        = 1'b0;
      LeerMem    = 1'b0;
      EscrMem    = 1'b0;
      EscrIR     = 1'b0;
      MemaReg    = 1'b0;
      RegDest    = 1'b0;
      EscrReg    = 1'b0;
      FuenteALUA = 1'b0;
      FuenteALUB = 2'b00;
      ALUOp      = '0;
      FuentePC   = 2'b00;
      excepcion  = 1'b0;
      estado     = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: per-cycle expected state/outputs queued with stimulus.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_listo = 1'b0;

  logic EscrPC, EscrPCCond, IoD, LeerMem, EscrMem, EscrIR, MemaReg, RegDest, EscrReg, FuenteALUA, excepcion;
  logic [1:0] FuenteALUB, ALUOp, FuentePC;
  logic [3:0] estado;
  logic b_EscrPC, b_EscrPCCond, b_IoD, b_LeerMem, b_EscrMem, b_EscrIR, b_MemaReg, b_RegDest, b_EscrReg;
  logic b_FuenteALUA, b_excepcion;
  logic [1:0] b_FuenteALUB, b_ALUOp, b_FuentePC;
  logic [3:0] b_estado;

  control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_listo(mem_listo),
    .EscrPC(EscrPC), .EscrPCCond(EscrPCCond), .IoD(IoD), .LeerMem(LeerMem), .EscrMem(EscrMem),
    .EscrIR(EscrIR), .MemaReg(MemaReg), .RegDest(RegDest), .EscrReg(EscrReg), .FuenteALUA(FuenteALUA),
    .FuenteALUB(FuenteALUB), .ALUOp(ALUOp), .FuentePC(FuentePC), .estado(estado), .excepcion(excepcion)
  );

  control_multiciclo #(.EN_INMED(0)) dut_noimm (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_listo(mem_listo),
    .EscrPC(b_EscrPC), .EscrPCCond(b_EscrPCCond), .IoD(b_IoD), .LeerMem(b_LeerMem), .EscrMem(b_EscrMem),
    .EscrIR(b_EscrIR), .MemaReg(b_MemaReg), .RegDest(b_RegDest), .EscrReg(b_EscrReg),
    .FuenteALUA(b_FuenteALUA), .FuenteALUB(b_FuenteALUB), .ALUOp(b_ALUOp), .FuentePC(b_FuentePC),
    .estado(b_estado), .excepcion(b_excepcion)
  );

  always #5 clk = ~clk;

  logic [16:0] obs, obs2;
  assign obs  = {EscrPC, EscrPCCond, IoD, LeerMem, EscrMem, EscrIR, MemaReg, RegDest, EscrReg,
                 FuenteALUA, FuenteALUB, ALUOp, FuentePC, excepcion};
  assign obs2 = {b_EscrPC, b_EscrPCCond, b_IoD, b_LeerMem, b_EscrMem, b_EscrIR, b_MemaReg, b_RegDest,
                 b_EscrReg, b_FuenteALUA, b_FuenteALUB, b_ALUOp, b_FuentePC, b_excepcion};

  localparam logic [16:0] B_EPC = 17'h10000, B_EPCC = 17'h08000, B_IOD = 17'h04000, B_LEER = 17'h02000;
  localparam logic [16:0] B_ESCRM = 17'h01000, B_EIR = 17'h00800, B_MAR = 17'h00400, B_RD = 17'h00200;
  localparam logic [16:0] B_EREG = 17'h00100, B_ALUA = 17'h00080, ALUB_4 = 17'h00020, ALUB_IMM = 17'h00040;
  localparam logic [16:0] ALUB_SH = 17'h00060, ALUOP_SUB = 17'h00008, ALUOP_FN = 17'h00010;
  localparam logic [16:0] PC_ALUOUT = 17'h00002, PC_JMP = 17'h00004, B_EXC = 17'h00001;

  localparam logic [16:0] O_FETCH_W = B_LEER | ALUB_4;
  localparam logic [16:0] O_FETCH_R = O_FETCH_W | B_EPC | B_EIR;
  localparam logic [16:0] O_DEC     = ALUB_SH;
  localparam logic [16:0] O_MEMADR  = B_ALUA | ALUB_IMM;
  localparam logic [16:0] O_MEMRD   = B_LEER | B_IOD;
  localparam logic [16:0] O_MEMWB   = B_EREG | B_MAR;
  localparam logic [16:0] O_MEMWR   = B_ESCRM | B_IOD;
  localparam logic [16:0] O_EXEC    = B_ALUA | ALUOP_FN;
  localparam logic [16:0] O_RWB     = B_EREG | B_RD;
  localparam logic [16:0] O_BRANCH  = B_ALUA | ALUOP_SUB | B_EPCC | PC_ALUOUT;
  localparam logic [16:0] O_JUMP    = B_EPC | PC_JMP;
  localparam logic [16:0] O_ADDIEX  = B_ALUA | ALUB_IMM;
  localparam logic [16:0] O_ADDIWB  = B_EREG;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

  typedef struct packed { logic [3:0] st; logic [16:0] o; } exp_t;
  typedef struct packed { logic listo; logic [5:0] op; } stim_t;

  exp_t  exp_q[$];
  exp_t  exp2_q[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic push(input logic l, input logic [5:0] op, input logic [3:0] st, input logic [16:0] o);
    stim_q.push_back({l, op});
    exp_q.push_back({st, o});
  endtask

  task automatic push2(input logic [3:0] st, input logic [16:0] o);
    exp2_q.push_back({st, o});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; int cyc = 0;
    reset = 1'b1; mem_listo = 1'b1; opcode = OP_BAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({estado, obs} !== 21'd0) begin
      n_err++; $display("FAIL reset_hold: estado=%0d out=%05h expected estado=0 out=00000", estado, obs);
    end
    n_cmp++;
    if ({b_estado, obs2} !== 21'd0) begin
      n_err++; $display("FAIL reset_hold_noimm: estado=%0d out=%05h expected estado=0 out=00000", b_estado, obs2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push(1'b1, OP_R, 4'd0, O_FETCH_R);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL reset_release cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_lw();
    stim_t s; exp_t e; int cyc = 0;
    do_reset();
    push(1, OP_R, 0, O_FETCH_R); push(1, OP_R, 1, O_DEC); push(1, OP_R, 6, O_EXEC); push(1, OP_R, 7, O_RWB);
    push(1, OP_LW, 0, O_FETCH_R); push(1, OP_LW, 1, O_DEC); push(1, OP_LW, 2, O_MEMADR);
    push(0, OP_LW, 3, O_MEMRD); push(0, OP_LW, 3, O_MEMRD); push(0, OP_LW, 3, O_MEMRD);
    push(1, OP_LW, 3, O_MEMRD); push(0, OP_LW, 4, O_MEMWB); push(0, OP_LW, 0, O_FETCH_W);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL rtype_lw cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    stim_t s; exp_t e; int cyc = 0;
    do_reset();
    push(1, OP_SW, 0, O_FETCH_R); push(0, OP_SW, 1, O_DEC); push(1, OP_SW, 2, O_MEMADR);
    push(0, OP_SW, 5, O_MEMWR); push(1, OP_SW, 5, O_MEMWR);
    push(1, OP_SW, 0, O_FETCH_R); push(1, OP_SW, 1, O_DEC); push(0, OP_SW, 2, O_MEMADR);
    for (int i = 0; i < 15; i++) push(0, OP_SW, 5, O_MEMWR);
    push(0, OP_SW, 5, (O_MEMWR & ~B_ESCRM) | B_EXC);
    for (int i = 0; i < 15; i++) push(0, OP_SW, 0, O_FETCH_W);
    push(0, OP_SW, 0, O_FETCH_W | B_EXC);
    push(0, OP_SW, 0, O_FETCH_W);
    push(1, OP_SW, 0, O_FETCH_R);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL sw_timeout cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_addi();
    stim_t s; exp_t e, e2; int cyc = 0;
    do_reset();
    push(1, OP_BAD, 0, O_FETCH_R);  push2(0, O_FETCH_R);
    push(1, OP_BAD, 1, O_DEC | B_EXC); push2(1, O_DEC | B_EXC);
    push(1, OP_ADDI, 0, O_FETCH_R); push2(0, O_FETCH_R);
    push(1, OP_ADDI, 1, O_DEC);     push2(1, O_DEC | B_EXC);
    push(1, OP_ADDI, 10, O_ADDIEX); push2(0, O_FETCH_R);
    push(1, OP_ADDI, 11, O_ADDIWB); push2(1, O_DEC | B_EXC);
    push(0, OP_ADDI, 0, O_FETCH_W); push2(0, O_FETCH_W);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); e2 = exp2_q.pop_front(); n_cmp += 2;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL illegal_addi cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      if ({b_estado, obs2} !== {e2.st, e2.o}) begin
        n_err++; $display("FAIL illegal_noimm cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, b_estado, obs2, e2.st, e2.o);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e; int cyc = 0;
    do_reset();
    push(1, OP_BEQ, 0, O_FETCH_R); push(1, OP_BEQ, 1, O_DEC); push(1, OP_BEQ, 8, O_BRANCH);
    push(1, OP_J, 0, O_FETCH_R);   push(1, OP_J, 1, O_DEC);   push(1, OP_J, 9, O_JUMP);
    push(1, OP_R, 0, O_FETCH_R);   push(1, OP_R, 1, O_DEC);   push(1, OP_R, 6, O_EXEC);
    push(1, OP_R, 7, O_RWB);
    push(1, OP_LW, 0, O_FETCH_R);  push(1, OP_LW, 1, O_DEC);  push(1, OP_LW, 2, O_MEMADR);
    push(1, OP_LW, 3, O_MEMRD);    push(1, OP_LW, 4, O_MEMWB);
    push(1, OP_SW, 0, O_FETCH_R);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL back_to_back cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    stim_t s; exp_t e; int cyc = 0;
    do_reset();
    push(1, OP_SW, 0, O_FETCH_R); push(1, OP_SW, 1, O_DEC); push(1, OP_SW, 2, O_MEMADR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); mem_listo = s.listo; opcode = s.op;
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({estado, obs} !== {e.st, e.o}) begin
        n_err++; $display("FAIL async_pre cyc%0d: estado=%0d out=%05h expected estado=%0d out=%05h",
                          cyc, estado, obs, e.st, e.o);
      end
      cyc++; @(posedge clk); #1;
    end
    mem_listo = 1'b1; #1;
    n_cmp++;
    if ({estado, obs} !== {4'd5, O_MEMWR}) begin
      n_err++; $display("FAIL async_memwr: estado=%0d out=%05h expected estado=5 out=%05h", estado, obs, O_MEMWR);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if ({estado, obs} !== 21'd0) begin
      n_err++; $display("FAIL async_abort: estado=%0d out=%05h expected estado=0 out=00000", estado, obs);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_listo = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({estado, obs} !== {4'd0, O_FETCH_W}) begin
      n_err++; $display("FAIL async_resume: estado=%0d out=%05h expected estado=0 out=%05h", estado, obs, O_FETCH_W);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rtype_lw();
    test_sw_timeout();
    test_illegal_addi();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
